// File: rtl/uart_tx_fifo.sv
// Transmit-side byte queue feeding a UART TX PISO.
// A small launch FSM pops one byte at a time and handshakes with the TX FSM.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       TXstart,
    input  logic                       TX_busy,
    output logic                       tx_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]       state_q,   state_d;
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             start_q,   start_d;
    logic             done_q,    done_d;

    logic push;
    logic pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign count    = count_q;
    assign tx_data  = tx_data_q;
    assign TXstart  = start_q;
    assign tx_done  = done_q;

    // A push in the flush cycle is dropped along with the queue.
    assign push = wr_valid && wr_ready && !flush;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !TX_busy && !flush) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                    start_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (TX_busy) begin
                    state_d = S_WAIT;
                    start_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!TX_busy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            start_q   <= start_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple TX FSM busy model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic [7:0] tx_data;
    logic       TXstart;
    logic       TX_busy = 1'b0;
    logic       tx_done;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt  = 0;
    int start_cnt = 0;
    logic start_prev = 1'b0;

    uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .flush    (flush),
        .tx_data  (tx_data),
        .TXstart  (TXstart),
        .TX_busy  (TX_busy),
        .tx_done  (tx_done),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (TXstart && !start_prev) start_cnt++;
        start_prev = TXstart;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    // Wait for a launch, act busy for busy_cyc cycles, then wait for tx_done.
    task automatic serve(input int busy_cyc, output logic [7:0] got);
        int n;
        n = 0;
        while (!TXstart && n < 100) begin
            step();
            n++;
        end
        chk("start_to", 32'(TXstart), 1);
        got = tx_data;
        TX_busy = 1'b1;
        step(busy_cyc);
        TX_busy = 1'b0;
        n = 0;
        while (!tx_done && n < 10) begin
            step();
            n++;
        end
        chk("done_to", 32'(tx_done), 1);
    endtask

    logic [7:0] got;
    int sc, dc;

    initial begin
        // reset values
        step(3);
        chk("rst_count",  32'(count), 0);
        chk("rst_empty",  32'(empty), 1);
        chk("rst_full",   32'(full), 0);
        chk("rst_ready",  32'(wr_ready), 1);
        chk("rst_start",  32'(TXstart), 0);
        chk("rst_done",   32'(tx_done), 0);
        chk("rst_txdata", 32'(tx_data), 0);
        rst = 1'b0;
        step();

        // single byte, push->pop->TXstart latency
        dc = done_cnt;
        push(8'hA5);
        chk("lat_count", 32'(count), 1);
        chk("lat_start0", 32'(TXstart), 0);
        step();
        chk("lat_start1", 32'(TXstart), 1);
        chk("lat_data", 32'(tx_data), 32'hA5);
        chk("lat_empty", 32'(empty), 1);
        step(3);
        chk("hold_start", 32'(TXstart), 1);
        TX_busy = 1'b1;
        step();
        chk("wait_start", 32'(TXstart), 0);
        step(19);
        chk("wait_data", 32'(tx_data), 32'hA5);
        chk("wait_done", 32'(tx_done), 0);
        TX_busy = 1'b0;
        step();
        chk("done_pulse", 32'(tx_done), 1);
        step();
        chk("done_low", 32'(tx_done), 0);
        step(3);
        chk("single_ndone", 32'(done_cnt - dc), 1);
        chk("single_empty", 32'(empty), 1);

        // fill and drain
        TX_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            step();
        end
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_ready", 32'(wr_ready), 0);
        wr_data = 8'hEE;
        step();
        wr_valid = 1'b0;
        chk("ovf_count", 32'(count), 16);
        chk("ovf_start", 32'(TXstart), 0);
        TX_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            serve(2, got);
            chk("drain_data", 32'(got), 32'(i));
        end
        step(2);
        chk("drain_empty", 32'(empty), 1);

        // pointer wrap, at most five queued
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 5; k++) begin
                push(8'(8'h40 + g * 5 + k));
            end
            for (int k = 0; k < 5; k++) begin
                serve(1, got);
                chk("wrap_data", 32'(got), 32'(8'h40 + g * 5 + k));
            end
        end
        step(2);

        // simultaneous push and pop at count 3, then flush in WAIT_DONE
        TX_busy = 1'b1;
        push(8'h71);
        push(8'h72);
        push(8'h73);
        chk("sim_pre", 32'(count), 3);
        TX_busy  = 1'b0;
        push(8'h74);
        chk("sim_count", 32'(count), 3);
        chk("sim_start", 32'(TXstart), 1);
        chk("sim_data", 32'(tx_data), 32'h71);
        TX_busy = 1'b1;
        step();
        push(8'h75);
        chk("fl_pre", 32'(count), 4);
        sc = start_cnt;
        dc = done_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        step(3);
        TX_busy = 1'b0;
        step(10);
        chk("fl_ndone", 32'(done_cnt - dc), 1);
        chk("fl_nstart", 32'(start_cnt - sc), 0);
        chk("fl_data", 32'(tx_data), 32'h71);
        push(8'h99);
        serve(1, got);
        chk("fl_ptrs", 32'(got), 32'h99);
        step(2);

        // flush in IDLE blocks the pop
        TX_busy = 1'b1;
        push(8'h11);
        chk("fi_pre", 32'(count), 1);
        sc = start_cnt;
        TX_busy = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fi_start", 32'(TXstart), 0);
        chk("fi_count", 32'(count), 0);
        step(3);
        chk("fi_nstart", 32'(start_cnt - sc), 0);

        // reset during LAUNCH
        push(8'h22);
        push(8'h23);
        chk("rl_start", 32'(TXstart), 1);
        chk("rl_count", 32'(count), 1);
        dc = done_cnt;
        #2 rst = 1'b1;
        step();
        chk("rl_start0", 32'(TXstart), 0);
        chk("rl_count0", 32'(count), 0);
        chk("rl_data0", 32'(tx_data), 0);
        rst = 1'b0;
        step(5);
        chk("rl_ndone", 32'(done_cnt - dc), 0);
        chk("rl_idle", 32'(TXstart), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
